// File: rtl/sdram_reqmod.sv
// Host-side request initiator for the SDRAM base module.
// Turns valid/ready requests (read, write, page read) into a one-hot call
// held until the matching done pulse, and forwards read beats as a
// registered output stream.
module sdram_reqmod #(
    parameter int unsigned PAGE_LEN = 256,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic [1:0]  iReqCmd,
    input  logic [23:0] iReqAddr,
    input  logic [15:0] iReqData,
    output logic        oReqDone,
    output logic        oRdValid,
    output logic [15:0] oRdData,
    output logic        oRdLast,
    output logic        oTimeout,
    output logic        oErr,
    output logic [2:0]  oCall,
    input  logic [2:0]  iDone,
    input  logic        iEn,
    output logic [23:0] oAddr,
    output logic [23:0] oAddrPage,
    output logic [15:0] oData,
    input  logic [15:0] iData
);

    localparam int unsigned BW = $clog2(PAGE_LEN + 1);
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] PAGE_BEATS = BW'(PAGE_LEN);

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_PAGE  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALL,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [2:0]    call_q, call_d;
    logic [23:0]   addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          done_q, done_d;
    logic          tmop_q, tmop_d;
    logic          err_q, err_d;
    logic          rdvalid_q, rdvalid_d;
    logic [15:0]   rddata_q, rddata_d;
    logic          rdlast_q, rdlast_d;

    logic [BW-1:0] exp_beats;
    logic [BW-1:0] beats_now;
    logic          is_rd_cmd;
    logic          beat_ok;

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            call_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            beat_q    <= '0;
            tmo_q     <= '0;
            done_q    <= 1'b0;
            tmop_q    <= 1'b0;
            err_q     <= 1'b0;
            rdvalid_q <= 1'b0;
            rddata_q  <= '0;
            rdlast_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            call_q    <= call_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            beat_q    <= beat_d;
            tmo_q     <= tmo_d;
            done_q    <= done_d;
            tmop_q    <= tmop_d;
            err_q     <= err_d;
            rdvalid_q <= rdvalid_d;
            rddata_q  <= rddata_d;
            rdlast_q  <= rdlast_d;
        end
    end

    // Next-state logic: request accept, call/done handshake, timeout, beat capture.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        call_d    = call_q;
        addr_d    = addr_q;
        data_d    = data_q;
        beat_d    = beat_q;
        tmo_d     = tmo_q;
        done_d    = 1'b0;
        tmop_d    = 1'b0;
        err_d     = err_q;
        rdvalid_d = 1'b0;
        rddata_d  = rddata_q;
        rdlast_d  = 1'b0;

        case (cmd_q)
            CMD_READ: exp_beats = BW'(1);
            CMD_PAGE: exp_beats = PAGE_BEATS;
            default:  exp_beats = '0;
        endcase
        is_rd_cmd = (cmd_q == CMD_READ) || (cmd_q == CMD_PAGE);
        // Beats past the expected count are dropped, so the counter never exceeds PAGE_LEN.
        beat_ok   = (state_q == S_CALL) && iEn && is_rd_cmd && (beat_q < exp_beats);
        // A beat arriving together with done still counts toward the check.
        beats_now = beat_q + (beat_ok ? BW'(1) : BW'(0));

        case (state_q)
            S_IDLE: begin
                if (iEn) err_d = 1'b1;
                if (iReqValid) begin
                    cmd_d  = iReqCmd;
                    addr_d = iReqAddr;
                    data_d = iReqData;
                    beat_d = '0;
                    tmo_d  = '0;
                    case (iReqCmd)
                        CMD_READ: begin
                            call_d  = 3'b001;
                            state_d = S_CALL;
                        end
                        CMD_WRITE: begin
                            call_d  = 3'b010;
                            state_d = S_CALL;
                        end
                        CMD_PAGE: begin
                            call_d  = 3'b100;
                            state_d = S_CALL;
                        end
                        default: begin
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                            state_d = S_GAP;
                        end
                    endcase
                end
            end
            S_CALL: begin
                tmo_d = tmo_q + TW'(1);
                if (beat_ok) begin
                    rdvalid_d = 1'b1;
                    rddata_d  = iData;
                    rdlast_d  = (beat_q == exp_beats - BW'(1));
                    beat_d    = beats_now;
                end else if (iEn) begin
                    err_d = 1'b1;
                end
                if ((iDone & call_q) != 3'b000) begin
                    call_d  = '0;
                    done_d  = 1'b1;
                    if (beats_now != exp_beats) err_d = 1'b1;
                    state_d = S_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    call_d  = '0;
                    done_d  = 1'b1;
                    tmop_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_GAP;
                end
            end
            default: begin
                if (iEn) err_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign oReqReady = (state_q == S_IDLE);
    assign oReqDone  = done_q;
    assign oRdValid  = rdvalid_q;
    assign oRdData   = rddata_q;
    assign oRdLast   = rdlast_q;
    assign oTimeout  = tmop_q;
    assign oErr      = err_q;
    assign oCall     = call_q;
    assign oAddr     = addr_q;
    assign oAddrPage = addr_q;
    assign oData     = data_q;

endmodule

// File: tb/tb_sdram_reqmod.sv
// Directed bench for sdram_reqmod with PAGE_LEN=4, TIMEOUT=16.
module tb_sdram_reqmod;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        iReqValid = 1'b0;
    logic        oReqReady;
    logic [1:0]  iReqCmd = '0;
    logic [23:0] iReqAddr = '0;
    logic [15:0] iReqData = '0;
    logic        oReqDone;
    logic        oRdValid;
    logic [15:0] oRdData;
    logic        oRdLast;
    logic        oTimeout;
    logic        oErr;
    logic [2:0]  oCall;
    logic [2:0]  iDone = '0;
    logic        iEn = 1'b0;
    logic [23:0] oAddr;
    logic [23:0] oAddrPage;
    logic [15:0] oData;
    logic [15:0] iData = '0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    sdram_reqmod #(.PAGE_LEN(4), .TIMEOUT(16)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqCmd(iReqCmd),
        .iReqAddr(iReqAddr), .iReqData(iReqData), .oReqDone(oReqDone),
        .oRdValid(oRdValid), .oRdData(oRdData), .oRdLast(oRdLast),
        .oTimeout(oTimeout), .oErr(oErr), .oCall(oCall), .iDone(iDone),
        .iEn(iEn), .oAddr(oAddr), .oAddrPage(oAddrPage), .oData(oData),
        .iData(iData)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [23:0] addr, input logic [15:0] data);
        iReqValid = 1'b1;
        iReqCmd   = cmd;
        iReqAddr  = addr;
        iReqData  = data;
        tick();
        iReqValid = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_ready", oReqReady, 1);
        check("rst_call", oCall, 0);
        check("rst_err", oErr, 0);
        check("rst_rdvalid", oRdValid, 0);
        check("rst_addr", oAddr, 0);

        // Write
        issue(2'b01, 24'h000123, 16'hBEEF);
        check("wr_call", oCall, 3'b010);
        check("wr_addr", oAddr, 24'h000123);
        check("wr_addrpage", oAddrPage, 24'h000123);
        check("wr_data", oData, 16'hBEEF);
        check("wr_notready", oReqReady, 0);
        tick(); tick();
        check("wr_call_held", oCall, 3'b010);
        iDone = 3'b010;
        tick();
        iDone = 3'b000;
        check("wr_call_drop", oCall, 0);
        check("wr_done", oReqDone, 1);
        check("wr_err", oErr, 0);
        check("wr_gap_notready", oReqReady, 0);
        tick();
        check("wr_done_pulse", oReqDone, 0);
        check("wr_ready", oReqReady, 1);

        // Read with a stray write-done during the call
        issue(2'b00, 24'h00ABCD, 16'h0000);
        check("rd_call", oCall, 3'b001);
        iDone = 3'b010;
        tick();
        iDone = 3'b000;
        check("rd_stray_call", oCall, 3'b001);
        check("rd_stray_done", oReqDone, 0);
        iEn = 1'b1; iData = 16'h5A5A;
        tick();
        iEn = 1'b0;
        check("rd_valid", oRdValid, 1);
        check("rd_data", oRdData, 16'h5A5A);
        check("rd_last", oRdLast, 1);
        iDone = 3'b001;
        tick();
        iDone = 3'b000;
        check("rd_call_drop", oCall, 0);
        check("rd_done", oReqDone, 1);
        check("rd_valid_off", oRdValid, 0);
        check("rd_err", oErr, 0);
        tick();
        check("rd_ready", oReqReady, 1);

        // Read with beat and done in the same cycle
        issue(2'b00, 24'h000010, 16'h0000);
        iEn = 1'b1; iData = 16'h1234; iDone = 3'b001;
        tick();
        iEn = 1'b0; iDone = 3'b000;
        check("rdsame_valid", oRdValid, 1);
        check("rdsame_data", oRdData, 16'h1234);
        check("rdsame_done", oReqDone, 1);
        check("rdsame_err", oErr, 0);
        tick();

        // Page read
        issue(2'b10, 24'h000400, 16'h0000);
        check("pg_call", oCall, 3'b100);
        for (int i = 1; i <= 4; i++) begin
            iEn = 1'b1; iData = 16'(i);
            tick();
            check("pg_valid", oRdValid, 1);
            check("pg_data", oRdData, 32'(i));
            check("pg_last", oRdLast, (i == 4) ? 1 : 0);
        end
        iEn = 1'b0;
        tick();
        check("pg_call_held", oCall, 3'b100);
        iDone = 3'b100;
        tick();
        iDone = 3'b000;
        check("pg_call_drop", oCall, 0);
        check("pg_done", oReqDone, 1);
        check("pg_err", oErr, 0);
        tick();
        check("pg_ready", oReqReady, 1);

        // Timeout: call asserted at accept edge, dropped 16 edges later
        issue(2'b00, 24'h000222, 16'h0000);
        for (int i = 0; i < 15; i++) tick();
        check("to_call_held", oCall, 3'b001);
        check("to_not_yet", oTimeout, 0);
        tick();
        check("to_call_drop", oCall, 0);
        check("to_done", oReqDone, 1);
        check("to_pulse", oTimeout, 1);
        check("to_err", oErr, 1);
        tick();
        check("to_pulse_end", oTimeout, 0);
        check("to_ready", oReqReady, 1);
        issue(2'b01, 24'h000333, 16'h1111);
        check("to_next_call", oCall, 3'b010);
        iDone = 3'b010;
        tick();
        iDone = 3'b000;
        check("to_next_done", oReqDone, 1);
        check("to_err_sticky", oErr, 1);
        tick();

        // Page read with an extra beat
        do_reset();
        check("rst2_err", oErr, 0);
        issue(2'b10, 24'h000800, 16'h0000);
        for (int i = 1; i <= 4; i++) begin
            iEn = 1'b1; iData = 16'(16'h0010 + i);
            tick();
        end
        check("ex_err_before", oErr, 0);
        iData = 16'h00FF;
        tick();
        iEn = 1'b0;
        check("ex_dropped", oRdValid, 0);
        check("ex_err", oErr, 1);
        check("ex_data_kept", oRdData, 16'h0014);
        iDone = 3'b100;
        tick();
        iDone = 3'b000;
        check("ex_done", oReqDone, 1);
        tick();

        // iEn outside CALL
        do_reset();
        iEn = 1'b1; iData = 16'h7777;
        tick();
        iEn = 1'b0;
        check("idle_en_valid", oRdValid, 0);
        check("idle_en_err", oErr, 1);

        // Reserved command
        do_reset();
        issue(2'b11, 24'h000444, 16'h2222);
        check("rsv_call", oCall, 0);
        check("rsv_done", oReqDone, 1);
        check("rsv_err", oErr, 1);
        check("rsv_notready", oReqReady, 0);
        tick();
        check("rsv_ready", oReqReady, 1);

        // Reset during a page read
        do_reset();
        issue(2'b10, 24'h000C00, 16'h3333);
        for (int i = 1; i <= 2; i++) begin
            iEn = 1'b1; iData = 16'(16'h0A00 + i);
            tick();
        end
        iEn = 1'b0;
        check("mr_call_before", oCall, 3'b100);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("mr_call", oCall, 0);
        check("mr_done", oReqDone, 0);
        check("mr_ready", oReqReady, 1);
        check("mr_rdvalid", oRdValid, 0);
        check("mr_rddata", oRdData, 0);
        check("mr_addr", oAddr, 0);
        check("mr_data", oData, 0);
        check("mr_err", oErr, 0);
        tick();
        check("mr_no_done", oReqDone, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_reqmod.md
Name: sdram_reqmod

Overview:
- Host-side initiator for the SDRAM base module's call/done interface.
- Accepts single-word read, single-word write and page-read requests on a valid/ready port.
- Converts each request into a one-hot call held until the matching done pulse.
- Captures read beats strobed by the enable line and forwards them as a registered output stream.
- Sits between graphics/pixel logic and the SDRAM base module.

Parameters:
- PAGE_LEN, 256, number of beats expected for a page read (CRead); must be ≥ 2.
- TIMEOUT, 4096, cycles in CALL without the matching done before the call is abandoned.

Ports:
- CLOCK  input  1  system clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- iReqValid  input  1  host request valid.
- oReqReady  output  1  high only in IDLE; a request is accepted when iReqValid & oReqReady.
- iReqCmd  input  2  00 read, 01 write, 10 page read, 11 reserved (accepted, then completes immediately with oErr set).
- iReqAddr  input  24  word address; page base for a page read.
- iReqData  input  16  write data.
- oReqDone  output  1  one-cycle pulse when a request completes or times out.
- oRdValid  output  1  read beat valid; no backpressure.
- oRdData  output  16  read beat data.
- oRdLast  output  1  marks the final expected beat (the only beat for a read; beat PAGE_LEN-1 for a page read).
- oTimeout  output  1  one-cycle pulse, coincident with oReqDone, on timeout.
- oErr  output  1  sticky error flag; cleared only by RESET.
- oCall  output  3  to SDRAM: [2] CRead, [1] Write, [0] Read; at most one bit set.
- iDone  input  3  from SDRAM: one-cycle done pulses, same bit order.
- iEn  input  1  from SDRAM: read data strobe.
- oAddr  output  24  latched request address.
- oAddrPage  output  24  latched request address, same value as oAddr.
- oData  output  16  latched write data.
- iData  input  16  read data from SDRAM, valid when iEn = 1.

Behaviour:
- RESET (synchronous, active-high): state → IDLE; oCall, oReqDone, oRdValid, oRdLast, oTimeout, oErr = 0; oRdData, oAddr, oAddrPage, oData = 0; beat and timeout counters = 0.
- RESET asserted mid-operation: oCall drops at that edge. No oReqDone is produced for the abandoned request.
- States: IDLE, CALL, GAP.
- IDLE:
  - oReqReady = 1.
  - On accept at edge k: latch cmd, addr and data; clear counters; go to CALL.
  - oCall one-hot is asserted from edge k (visible in cycle k+1).
  - A reserved command skips CALL: goes to GAP, pulses oReqDone and sets oErr.
- CALL:
  - oCall, oAddr and oData are held constant.
  - The timeout counter increments every cycle.
  - On iDone bit matching the issued call:
    - oCall ← 0 and oReqDone pulses next cycle.
    - If beats received ≠ expected (read: 1, write: 0, page read: PAGE_LEN), set oErr.
    - Go to GAP.
  - A non-matching iDone bit is ignored.
  - If the counter reaches TIMEOUT-1 with no matching done: oCall ← 0, pulse oReqDone and oTimeout, set oErr, go to GAP.
- GAP: one cycle with oCall = 0 (guarantees a call low period between requests), then IDLE. oReqReady returns 2 cycles after the matching iDone.
- Read capture:
  - iEn = 1 in cycle t during a read or page-read CALL → oRdValid = 1 and oRdData = iData in cycle t+1 (1-cycle latency). The beat counter increments.
  - oRdLast is asserted with the beat whose index equals expected-1.
- Boundary conditions:
  - iEn beyond the expected count: beat dropped (oRdValid stays 0), oErr set.
  - iEn during a write call or outside CALL: ignored, oErr set.
  - iEn and matching iDone in the same cycle: the beat is counted before the count check.
- Counters: the beat counter is wide enough for PAGE_LEN and saturates rather than wrapping. The timeout counter stops in IDLE/GAP.

Test Plan:
- Write: req cmd=01 addr=0x000123 data=0xBEEF → oCall=3'b010 next cycle with oAddr=0x000123, oData=0xBEEF; iDone[1] pulse → oCall=0 and oReqDone pulse next cycle; oErr=0; ready 2 cycles after iDone.
- Read: cmd=00 addr=0x00ABCD, model gives iEn with iData=0x5A5A then iDone[0] → oRdValid/oRdLast=1 with oRdData=0x5A5A one cycle after iEn; oErr=0.
- Page read PAGE_LEN=4: cmd=10, model streams 0x0001..0x0004 → 4 oRdValid beats in order, oRdLast only on 0x0004; oCall=3'b100 until iDone[2].
- Timeout TIMEOUT=16: read with no iDone → oCall drops 16 cycles after assertion; oReqDone and oTimeout pulse; oErr=1; next request accepted.
- Error cases: page read with 5 iEn beats → 5th dropped, oErr=1. Stray iDone[1] during a read call → ignored, call still held.
- Reset mid page read after 2 beats → all outputs 0 the following cycle, no oReqDone, oReqReady=1.
